// File: rtl/game_sequencer.sv
// game_sequencer: central game controller. Broadcasts a 3-bit state code to the per-row
// Block instances, paces piece falling with a gravity divider, sequences
// spawn -> fall -> write -> clear/shift, and counts cleared lines (saturating at 16'hFFFF).
// Optional feature macro: SOFT_DROP_EN adds the soft_drop input. While soft_drop is high in
// FALL, the gravity terminal count shortens to (GRAVITY_DIV>>3)-1, with a minimum of 1.
// The handshake with the Blocks is level-sampled and has no valid/ready pair:
//   stop_in is sampled only in MOVE_CHK,
//   endgame_in is sampled only in ADD_CHK,
//   full_rows is sampled only in CHECK.
// Each code is held for exactly the cycles of its state, so the Blocks act on the code they see.
module game_sequencer #(
   parameter int ROWS        = 20,
   parameter int GRAVITY_DIV = 25_000_000,
   parameter int RIDX_W      = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop_in,
   input  logic              endgame_in,
   input  logic [ROWS-1:0]   full_rows,
`ifdef SOFT_DROP_EN
   input  logic              soft_drop,
`endif
   output logic [2:0]        state_code,
   output logic [RIDX_W-1:0] shift_row,
   output logic [15:0]       lines,
   output logic              game_over,
   output logic              busy,
   output logic [3:0]        o_dbg_state
);

   localparam int CNT_W = (GRAVITY_DIV > 2) ? $clog2(GRAVITY_DIV) : 1;
   localparam logic [CNT_W-1:0] C_TERM = CNT_W'(GRAVITY_DIV - 1);
`ifdef SOFT_DROP_EN
   localparam int SOFT_TERM = ((GRAVITY_DIV >> 3) > 1) ? ((GRAVITY_DIV >> 3) - 1) : 1;
   localparam logic [CNT_W-1:0] C_SOFT_TERM = CNT_W'(SOFT_TERM);
`endif

   localparam logic [2:0] C_CHK   = 3'b000;
   localparam logic [2:0] C_MOVE  = 3'b001;
   localparam logic [2:0] C_WRITE = 3'b010;
   localparam logic [2:0] C_SHIFT = 3'b011;
   localparam logic [2:0] C_ADD   = 3'b100;
   localparam logic [2:0] C_HOLD  = 3'b111;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_ADD      = 4'd1,
      S_ADD_CHK  = 4'd2,
      S_FALL     = 4'd3,
      S_MOVE     = 4'd4,
      S_MOVE_CHK = 4'd5,
      S_WRITE    = 4'd6,
      S_CHECK    = 4'd7,
      S_SHIFT    = 4'd8,
      S_SETTLE   = 4'd9,
      S_HALT     = 4'd10
   } state_t;

   state_t             r_state;
   logic [2:0]         r_code;
   logic [RIDX_W-1:0]  r_shift_row;
   logic [15:0]        r_lines;
   logic               r_game_over;
   logic               r_busy;
   logic [CNT_W-1:0]   r_cnt;

   logic [RIDX_W-1:0]  w_low_idx;
   logic               w_fall_done;

   // Index of the lowest full row; bottom-most row is cleared first
   always_comb begin
      w_low_idx = '0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (full_rows[i]) w_low_idx = RIDX_W'(i);
      end
   end

   // Gravity terminal count reached (shortened while soft drop is requested)
   always_comb begin
      w_fall_done = (r_cnt >= C_TERM);
`ifdef SOFT_DROP_EN
      if (soft_drop && (r_cnt >= C_SOFT_TERM)) w_fall_done = 1'b1;
`endif
   end

   // Main sequencer: state, registered broadcast code and status outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_code      <= C_HOLD;
         r_shift_row <= '0;
         r_lines     <= '0;
         r_game_over <= 1'b0;
         r_busy      <= 1'b0;
         r_cnt       <= '0;
      end else begin
         // The counter only advances while in FALL, so it is always zero on entry
         r_cnt <= '0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_ADD;
                  r_code  <= C_ADD;
                  r_busy  <= 1'b1;
               end
            end
            S_ADD: begin
               r_state <= S_ADD_CHK;
               r_code  <= C_HOLD;
            end
            S_ADD_CHK: begin
               if (endgame_in) begin
                  r_state     <= S_HALT;
                  r_code      <= C_CHK;
                  r_busy      <= 1'b0;
                  r_game_over <= 1'b1;
               end else begin
                  r_state <= S_FALL;
                  r_code  <= C_HOLD;
               end
            end
            S_FALL: begin
               if (w_fall_done) begin
                  r_state <= S_MOVE;
                  r_code  <= C_MOVE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_MOVE: begin
               r_state <= S_MOVE_CHK;
               r_code  <= C_HOLD;
            end
            S_MOVE_CHK: begin
               if (stop_in) begin
                  r_state <= S_WRITE;
                  r_code  <= C_WRITE;
               end else begin
                  r_state <= S_FALL;
                  r_code  <= C_HOLD;
               end
            end
            S_WRITE: begin
               r_state <= S_CHECK;
               r_code  <= C_CHK;
            end
            S_CHECK: begin
               if (full_rows == '0) begin
                  r_state <= S_ADD;
                  r_code  <= C_ADD;
               end else begin
                  r_shift_row <= w_low_idx;
                  r_state     <= S_SHIFT;
                  r_code      <= C_SHIFT;
               end
            end
            S_SHIFT: begin
               if (r_lines != 16'hFFFF) r_lines <= r_lines + 16'd1;
               r_state <= S_SETTLE;
               r_code  <= C_HOLD;
            end
            S_SETTLE: begin
               // One idle cycle lets the row array re-evaluate full_rows after the shift
               r_state <= S_CHECK;
               r_code  <= C_CHK;
            end
            S_HALT: begin
               r_state     <= S_HALT;
               r_code      <= C_CHK;
               r_busy      <= 1'b0;
               r_game_over <= 1'b1;
            end
            default: begin
               r_state     <= S_IDLE;
               r_code      <= C_HOLD;
               r_busy      <= 1'b0;
               r_game_over <= 1'b0;
            end
         endcase
      end
   end

   assign state_code  = r_code;
   assign shift_row   = r_shift_row;
   assign lines       = r_lines;
   assign game_over   = r_game_over;
   assign busy        = r_busy;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: testbench for game_sequencer (ROWS=20). It uses GRAVITY_DIV=4, or 16
// when SOFT_DROP_EN is defined. Each vector holds the outputs expected in the current cycle
// and the inputs to drive during that cycle. Directed vectors come first; randomized games
// from a game-level model follow.
module tb_game_sequencer;

   localparam int ROWS = 20;
   localparam int RW   = 5;
`ifdef SOFT_DROP_EN
   localparam int DIV  = 16;
`else
   localparam int DIV  = 4;
`endif
   localparam int ST   = ((DIV >> 3) > 1) ? ((DIV >> 3) - 1) : 1;

   logic            clk;
   logic            reset;
   logic            start;
   logic            stop_in;
   logic            endgame_in;
   logic [ROWS-1:0] full_rows;
   logic            soft_drop;
   logic [2:0]      state_code;
   logic [RW-1:0]   shift_row;
   logic [15:0]     lines;
   logic            game_over;
   logic            busy;
   logic [3:0]      dbg_state;

   game_sequencer #(.ROWS(ROWS), .GRAVITY_DIV(DIV), .RIDX_W(RW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop_in    (stop_in),
      .endgame_in (endgame_in),
      .full_rows  (full_rows),
`ifdef SOFT_DROP_EN
      .soft_drop  (soft_drop),
`endif
      .state_code (state_code),
      .shift_row  (shift_row),
      .lines      (lines),
      .game_over  (game_over),
      .busy       (busy),
      .o_dbg_state(dbg_state)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic            rst;
      logic            st;
      logic            sp;
      logic            eg;
      logic            sd;
      logic [ROWS-1:0] fr;
      logic [2:0]      code;
      logic [RW-1:0]   srow;
      logic [15:0]     ln;
      logic            go;
      logic            bz;
   } vec_t;

   vec_t tab[$];
   int   checks = 0;
   int   errors = 0;

   logic [RW-1:0] m_srow;
   logic [15:0]   m_lines;

   // append one vector to the table
   task automatic add(input logic [2:0] c, input logic [RW-1:0] sr, input logic [15:0] ln,
                      input logic go, input logic bz, input logic rs, input logic st,
                      input logic sp, input logic eg, input logic sd, input logic [ROWS-1:0] fr);
      vec_t v;
      v.rst = rs; v.st = st; v.sp = sp; v.eg = eg; v.sd = sd; v.fr = fr;
      v.code = c; v.srow = sr; v.ln = ln; v.go = go; v.bz = bz;
      tab.push_back(v);
   endtask

   // driver: compare the current outputs, then drive the vector inputs across one edge
   task automatic run_table();
      for (int i = 0; i < tab.size(); i++) begin
         checks++;
         if ({state_code, shift_row, lines, game_over, busy} !==
             {tab[i].code, tab[i].srow, tab[i].ln, tab[i].go, tab[i].bz}) begin
            errors++;
            $display("FAIL vec%0d: got code=%b srow=%0d lines=%0d go=%b busy=%b, want code=%b srow=%0d lines=%0d go=%b busy=%b",
                     i, state_code, shift_row, lines, game_over, busy,
                     tab[i].code, tab[i].srow, tab[i].ln, tab[i].go, tab[i].bz);
         end
         reset      = tab[i].rst;
         start      = tab[i].st;
         stop_in    = tab[i].sp;
         endgame_in = tab[i].eg;
         soft_drop  = tab[i].sd;
         full_rows  = tab[i].fr;
         @(posedge clk);
         #1;
      end
      tab.delete();
   endtask

   function automatic logic [ROWS-1:0] noise();
      return ROWS'($urandom);
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // reference model helpers: lowest full row, and the playfield after that row is removed
   function automatic int lowest(input logic [ROWS-1:0] p);
      for (int i = 0; i < ROWS; i++) if (p[i]) return i;
      return 0;
   endfunction

   function automatic logic [ROWS-1:0] remove_row(input logic [ROWS-1:0] p, input int r);
      logic [ROWS-1:0] below;
      logic [ROWS-1:0] above;
      below = p & ((ROWS'(1) << r) - ROWS'(1));
      above = (p >> (r + 1)) << r;
      return below | above;
   endfunction

   // one game: idle, pieces falling and clearing rows, then endgame -> HALT -> reset
   task automatic gen_game();
      int npieces;
      int nf;
      int flen;
      logic sd;
      logic [ROWS-1:0] pat;
      m_lines = '0;
      m_srow  = '0;
      repeat ($urandom_range(0, 2))
         add(3'b111, m_srow, m_lines, 0, 0, 1, 0, rb(), rb(), rb(), noise());
      add(3'b111, m_srow, m_lines, 0, 0, 1, 1, rb(), rb(), rb(), noise());
      npieces = $urandom_range(1, 4);
      for (int p = 0; p < npieces; p++) begin
         add(3'b100, m_srow, m_lines, 0, 1, 1, rb(), rb(), rb(), rb(), noise());
         add(3'b111, m_srow, m_lines, 0, 1, 1, rb(), rb(), (p == npieces - 1), rb(), noise());
         if (p == npieces - 1) break;
         nf = $urandom_range(1, 3);
         for (int f = 0; f < nf; f++) begin
`ifdef SOFT_DROP_EN
            sd = rb();
`else
            sd = 1'b0;
`endif
            flen = sd ? (ST + 1) : DIV;
            for (int c = 0; c < flen; c++)
               add(3'b111, m_srow, m_lines, 0, 1, 1, rb(), rb(), rb(), sd, noise());
            add(3'b001, m_srow, m_lines, 0, 1, 1, rb(), rb(), rb(), rb(), noise());
            add(3'b111, m_srow, m_lines, 0, 1, 1, rb(), (f == nf - 1), rb(), rb(), noise());
         end
         add(3'b010, m_srow, m_lines, 0, 1, 1, rb(), rb(), rb(), rb(), noise());
         pat = ($urandom_range(0, 2) == 0) ? '0 : (noise() & noise() & noise());
         while (pat != '0) begin
            add(3'b000, m_srow, m_lines, 0, 1, 1, rb(), rb(), rb(), rb(), pat);
            m_srow = RW'(lowest(pat));
            add(3'b011, m_srow, m_lines, 0, 1, 1, rb(), rb(), rb(), rb(), noise());
            if (m_lines != 16'hFFFF) m_lines = m_lines + 16'd1;
            add(3'b111, m_srow, m_lines, 0, 1, 1, rb(), rb(), rb(), rb(), noise());
            pat = remove_row(pat, lowest(pat));
         end
         add(3'b000, m_srow, m_lines, 0, 1, 1, rb(), rb(), rb(), rb(), '0);
      end
      repeat ($urandom_range(0, 2))
         add(3'b000, m_srow, m_lines, 1, 0, 1, rb(), rb(), rb(), rb(), noise());
      add(3'b000, m_srow, m_lines, 1, 0, 0, rb(), rb(), rb(), rb(), noise());
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; stop_in = 1'b0; endgame_in = 1'b0;
      soft_drop = 1'b0; full_rows = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // directed table: reset state, first game with a two-row clear, then endgame/HALT
      add(3'b111, 0, 0, 0, 0, 1, 0, 0, 0, 0, '0);
      add(3'b111, 0, 0, 0, 0, 1, 1, 0, 0, 0, '0);
      add(3'b100, 0, 0, 0, 1, 1, 0, 0, 0, 0, '0);
      add(3'b111, 0, 0, 0, 1, 1, 0, 1, 0, 0, '0);
      for (int c = 0; c < DIV; c++) add(3'b111, 0, 0, 0, 1, 1, 1, 1, 1, 0, '1);
      add(3'b001, 0, 0, 0, 1, 1, 0, 1, 0, 0, '0);
      add(3'b111, 0, 0, 0, 1, 1, 0, 0, 0, 0, '0);
      for (int c = 0; c < DIV; c++) add(3'b111, 0, 0, 0, 1, 1, 0, 0, 0, 0, '0);
      add(3'b001, 0, 0, 0, 1, 1, 0, 0, 0, 0, '0);
      add(3'b111, 0, 0, 0, 1, 1, 0, 1, 0, 0, '0);
      add(3'b010, 0, 0, 0, 1, 1, 0, 0, 0, 0, '0);
      add(3'b000, 0, 0, 0, 1, 1, 0, 0, 0, 0, 20'h00005);
      add(3'b011, 0, 0, 0, 1, 1, 0, 0, 0, 0, 20'h00005);
      add(3'b111, 0, 1, 0, 1, 1, 0, 0, 0, 0, 20'h00002);
      add(3'b000, 0, 1, 0, 1, 1, 0, 0, 0, 0, 20'h00002);
      add(3'b011, 1, 1, 0, 1, 1, 0, 0, 0, 0, '0);
      add(3'b111, 1, 2, 0, 1, 1, 0, 0, 0, 0, '0);
      add(3'b000, 1, 2, 0, 1, 1, 0, 0, 0, 0, '0);
      add(3'b100, 1, 2, 0, 1, 1, 0, 0, 0, 0, '0);
      add(3'b111, 1, 2, 0, 1, 1, 0, 0, 1, 0, '0);
      add(3'b000, 1, 2, 1, 0, 1, 1, 0, 0, 0, '0);
      add(3'b000, 1, 2, 1, 0, 1, 1, 0, 0, 0, '0);
      add(3'b000, 1, 2, 1, 0, 0, 0, 0, 0, 0, '0);
      add(3'b111, 0, 0, 0, 0, 1, 0, 0, 0, 0, '0);
      run_table();

      // hand-written: reset asserted during SHIFT aborts, lines not incremented
      add(3'b111, 0, 0, 0, 0, 1, 1, 0, 0, 0, '0);
      add(3'b100, 0, 0, 0, 1, 1, 0, 0, 0, 0, '0);
      add(3'b111, 0, 0, 0, 1, 1, 0, 0, 0, 0, '0);
      for (int c = 0; c < DIV; c++) add(3'b111, 0, 0, 0, 1, 1, 0, 1, 0, 0, '0);
      add(3'b001, 0, 0, 0, 1, 1, 0, 0, 0, 0, '0);
      add(3'b111, 0, 0, 0, 1, 1, 0, 1, 0, 0, '0);
      add(3'b010, 0, 0, 0, 1, 1, 0, 0, 0, 0, '0);
      add(3'b000, 0, 0, 0, 1, 1, 0, 0, 0, 0, 20'h80000);
      add(3'b011, 19, 0, 0, 1, 0, 0, 0, 0, 0, '0);
      add(3'b111, 0, 0, 0, 0, 1, 0, 0, 0, 0, '0);
      run_table();

`ifdef SOFT_DROP_EN
      // hand-written: soft drop shortens each fall to ST+1 cycles
      add(3'b111, 0, 0, 0, 0, 1, 1, 0, 0, 0, '0);
      add(3'b100, 0, 0, 0, 1, 1, 0, 0, 0, 1, '0);
      add(3'b111, 0, 0, 0, 1, 1, 0, 0, 0, 1, '0);
      for (int f = 0; f < 2; f++) begin
         for (int c = 0; c <= ST; c++) add(3'b111, 0, 0, 0, 1, 1, 0, 0, 0, 1, '0);
         add(3'b001, 0, 0, 0, 1, 1, 0, 0, 0, 1, '0);
         add(3'b111, 0, 0, 0, 1, 1, 0, (f == 1), 0, 1, '0);
      end
      add(3'b010, 0, 0, 0, 1, 1, 0, 0, 0, 0, '0);
      add(3'b000, 0, 0, 0, 1, 1, 0, 0, 0, 0, '0);
      add(3'b100, 0, 0, 0, 1, 0, 0, 0, 0, 0, '0);
      add(3'b111, 0, 0, 0, 0, 1, 0, 0, 0, 0, '0);
      run_table();
`endif

      // randomized games against the game-level model
      for (int g = 0; g < 8; g++) gen_game();
      add(3'b111, 0, 0, 0, 0, 1, 0, 0, 0, 0, '0);
      run_table();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
